// File: rtl/fifo_drain_pkg.sv
// Shared state encoding for the FIFO drain stage skid buffer.
package fifo_drain_pkg;
  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;
endpackage

// File: rtl/fifo_drain_stage_ff.sv
// Enabled register with synchronous active-high reset to INIT; no latency beyond one edge.
module fifo_drain_stage_ff #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);
  always_ff @(posedge clk) begin
    if (rst)     Q <= INIT;
    else if (en) Q <= D;
  end
endmodule

// File: rtl/fifo_drain_stage.sv
// FIFO empty/pop to registered valid/ready via 2-entry skid; 1-cycle latency, pop never depends on out_ready.
// Optional FIFO_DRAIN_STAGE_FORMAL_EN embeds interface assertions; port list and behaviour are unchanged.
module fifo_drain_stage
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CNTWID = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [WIDTH-1:0]  fifo_data,
  output logic              fifo_pop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        occupancy,
  output logic [CNTWID-1:0] xfer_count
);
  logic              w_fire;
  logic              w_h_en;
  logic              w_s_en;
  logic [WIDTH-1:0]  w_h_d;
  logic [WIDTH-1:0]  w_h_q;
  logic [WIDTH-1:0]  w_s_q;
  logic [ST_W-1:0]   w_state_q;
  state_t            w_state;
`ifdef FIFO_DRAIN_STAGE_FORMAL_EN
  (* keep *) state_t w_state_nxt;
`else
  state_t            w_state_nxt;
`endif
  logic [CNTWID-1:0] r_xfer_cnt;

  assign w_state    = state_t'(w_state_q);
  assign fifo_pop   = !rst && !fifo_empty && (w_state != ST_TWO);
  assign out_valid  = (w_state != ST_EMPTY);
  assign out_data   = w_h_q;
  assign occupancy  = w_state_q;
  assign w_fire     = out_valid && out_ready;
  assign xfer_count = r_xfer_cnt;

  // A popped word goes to H when H frees up this cycle, otherwise parks in S.
  always_comb begin
    w_state_nxt = w_state;
    w_h_en      = 1'b0;
    w_s_en      = 1'b0;
    w_h_d       = fifo_data;
    case (w_state)
      ST_EMPTY: begin
        if (fifo_pop) begin
          w_state_nxt = ST_ONE;
          w_h_en      = 1'b1;
        end
      end
      ST_ONE: begin
        if (fifo_pop && w_fire) begin
          w_h_en = 1'b1;
        end else if (fifo_pop) begin
          w_state_nxt = ST_TWO;
          w_s_en      = 1'b1;
        end else if (w_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_fire) begin
          w_state_nxt = ST_ONE;
          w_h_en      = 1'b1;
          w_h_d       = w_s_q;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  fifo_drain_stage_ff #(.WIDTH(WIDTH)) u_h_reg (
    .clk(clk), .rst(rst), .en(w_h_en), .D(w_h_d), .Q(w_h_q)
  );

  fifo_drain_stage_ff #(.WIDTH(WIDTH)) u_s_reg (
    .clk(clk), .rst(rst), .en(w_s_en), .D(fifo_data), .Q(w_s_q)
  );

  fifo_drain_stage_ff #(.WIDTH(ST_W)) u_state_reg (
    .clk(clk), .rst(rst), .en(1'b1), .D(w_state_nxt), .Q(w_state_q)
  );

  always_ff @(posedge clk) begin
    if (rst)         r_xfer_cnt <= '0;
    else if (w_fire) r_xfer_cnt <= r_xfer_cnt + CNTWID'(1);
  end

`ifdef FIFO_DRAIN_STAGE_FORMAL_EN
  logic             r_fv_stall;
  logic [WIDTH-1:0] r_fv_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fv_stall <= 1'b0;
      r_fv_data  <= '0;
    end else begin
      r_fv_stall <= out_valid && !out_ready;
      r_fv_data  <= out_data;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_pop && fifo_empty));
      assert (occupancy <= 2'd2);
      if (r_fv_stall) assert (out_valid && (out_data == r_fv_data));
      if (fifo_pop) assert (w_state != ST_TWO);
    end
  end
`endif
endmodule

// File: tb/tb_fifo_drain_stage.sv
module tb_fifo_drain_stage;
  localparam int WIDTH  = 8;
  localparam int CNTWID = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fifo_empty;
  logic [WIDTH-1:0]  fifo_data;
  logic              fifo_pop;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        occupancy;
  logic [CNTWID-1:0] xfer_count;

  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic       flush  = 1'b0;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] exp_q [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'd0;

  fifo_drain_stage #(.WIDTH(WIDTH), .CNTWID(CNTWID)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: combinational head, pointer advances on the popping edge.
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr];

  always @(posedge clk) begin
    if (flush)         rd_ptr <= wr_ptr;
    else if (fifo_pop) rd_ptr <= rd_ptr + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr      = wr_ptr + 8'd1;
    exp_q.push_back(v);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    flush     = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    flush = 1'b0;
    exp_q.delete();
    rst = 1'b0;
  endtask

  // Monitor: outputs sampled mid-cycle, fire resolves on the following edge.
  always @(negedge clk) begin
    if (rst) begin
      check("pop_during_rst", {31'd0, fifo_pop}, 32'd0);
      prev_stall = 1'b0;
    end else begin
      if (fifo_empty) check("pop_when_empty", {31'd0, fifo_pop}, 32'd0);
      if (prev_stall) begin
        check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        check("stall_hold_data", {24'd0, out_data}, {24'd0, prev_data});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL spurious_beat: got data %0h with nothing expected", out_data);
        end else begin
          check("beat_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_occ", {30'd0, occupancy}, 32'd0);
    check("rst_xfer", {28'd0, xfer_count}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);

    // Single word
    out_ready = 1'b1;
    push(8'hA5);
    #1;
    check("single_pop", {31'd0, fifo_pop}, 32'd1);
    tick();
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_data", {24'd0, out_data}, 32'hA5);
    check("single_occ1", {30'd0, occupancy}, 32'd1);
    tick();
    check("single_xfer", {28'd0, xfer_count}, 32'd1);
    check("single_occ0", {30'd0, occupancy}, 32'd0);

    // Streaming, no bubbles after the first beat
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_data", {24'd0, out_data}, i);
    end
    tick();
    check("stream_xfer", {28'd0, xfer_count}, 32'd8);
    check("stream_idle", {31'd0, out_valid}, 32'd0);

    // Backpressure
    do_reset();
    push(8'h10);
    push(8'h11);
    push(8'h12);
    tick();
    check("bp_occ1", {30'd0, occupancy}, 32'd1);
    tick();
    check("bp_occ2", {30'd0, occupancy}, 32'd2);
    check("bp_no_pop", {31'd0, fifo_pop}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("bp_hold_data", {24'd0, out_data}, 32'h10);
    check("bp_hold_occ", {30'd0, occupancy}, 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("bp_xfer", {28'd0, xfer_count}, 32'd3);
    check("bp_drained", {30'd0, occupancy}, 32'd0);

    // Random ready over 64 words
    do_reset();
    for (int i = 0; i < 64; i++) push(8'(i));
    for (int c = 0; c < 4000 && exp_q.size() > 0; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL rand_timeout: %0d words outstanding, expected 0", exp_q.size());
    end
    out_ready = 1'b0;
    tick();
    check("rand_xfer", {28'd0, xfer_count}, 32'd0);
    check("rand_occ", {30'd0, occupancy}, 32'd0);

    // Reset mid-operation with H=0x20, S=0x21
    do_reset();
    out_ready = 1'b1;
    push(8'h1F);
    tick();
    tick();
    out_ready = 1'b0;
    push(8'h20);
    push(8'h21);
    push(8'h22);
    tick();
    tick();
    check("mid_occ2", {30'd0, occupancy}, 32'd2);
    check("mid_head", {24'd0, out_data}, 32'h20);
    check("mid_xfer_pre", {28'd0, xfer_count}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_pop_in_rst", {31'd0, fifo_pop}, 32'd0);
    check("mid_valid", {31'd0, out_valid}, 32'd0);
    check("mid_occ0", {30'd0, occupancy}, 32'd0);
    check("mid_xfer0", {28'd0, xfer_count}, 32'd0);
    check("mid_data0", {24'd0, out_data}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    rst = 1'b0;
    tick();
    check("mid_after_valid", {31'd0, out_valid}, 32'd0);

    // Counter wrap: 17 transfers on a 4-bit counter
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
    for (int i = 0; i < 18; i++) tick();
    check("wrap_xfer", {28'd0, xfer_count}, 32'd1);
    check("wrap_queue", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
